dram_timed_controller: RTL and testbench
========================================

Name: dram_timed_controller

Overview:
- Next-generation single-rank DRAM command controller that sits between a user request port and a DRAM device.
- Adds over the previous controller: valid/ready request handshake, and programmable timing (tRCD, tRP, tRFC, CAS latency) enforced by internal counters.
- Also adds: internally timed refresh (no dram_refresh_done input), precharge-all, selectable open/close page policy, and a CAS-latency read-return pipeline.
- Per-bank open-row tracking is retained.

Parameters:
- NUMBER_OF_COLUMNS, 8, columns per row
- NUMBER_OF_ROWS, 128, rows per bank
- NUMBER_OF_BANKS, 8, banks
- DATA_WIDTH, 8, user and DRAM data width
- T_RCD, 2, cycles from ACTIVATE to column command (>=1)
- T_RP, 2, cycles from PRECHARGE to next command (>=1)
- T_RFC, 4, cycles from REFRESH to next command (>=1)
- CAS_LATENCY, 2, cycles from READ to valid dram_rd_data (>=1)
- REFRESH_INTERVAL, 1250, cycles between refresh requests
- CLOSE_PAGE, 0, 1 = auto-precharge the bank after every column command
- Derived (do not override):
  - COLUMN_WIDTH = clog2(columns)
  - ROW_WIDTH = clog2(rows)
  - BANK_ID_WIDTH = clog2(banks)
  - U_ADDR_WIDTH = sum of the three above
  - DRAM_ADDR_WIDTH = max(ROW_WIDTH, COLUMN_WIDTH)

Ports:
- u_clk  in  1  clock; all logic on rising edge
- u_rst  in  1  asynchronous, active-high reset
- u_req_valid  in  1  request present
- u_req_ready  out  1  controller accepts a request this cycle
- u_req_we  in  1  1 = write, 0 = read
- u_addr  in  U_ADDR_WIDTH  {bank, row, col}
- u_wdata  in  DATA_WIDTH  write data
- u_rdata  out  DATA_WIDTH  read data
- u_rdata_valid  out  1  single-cycle strobe qualifying u_rdata
- u_busy  out  1  state != IDLE
- dram_rd_data  in  DATA_WIDTH  device read data
- dram_wr_data  out  DATA_WIDTH  write data
- dram_addr  out  DRAM_ADDR_WIDTH  row or column address
- dram_bank_id  out  BANK_ID_WIDTH  bank
- dram_pre_all  out  1  qualifies PRECHARGE as all-bank
- dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  1 each  command pins
- dram_clk_en  out  1  clock enable

Behaviour:
- Reset (async assert):
  - u_req_ready=0, u_rdata=0, u_rdata_valid=0, u_busy=0, dram_clk_en=0.
  - Command pins all 1, dram_pre_all=0, dram_addr=0, dram_bank_id=0, dram_wr_data=0.
  - All banks closed; refresh pending=0; refresh counter=REFRESH_INTERVAL-1; read pipeline cleared.
- After reset release: dram_clk_en=1, dram_cs_n=0.
- Command encoding (ras,cas,we):
  - NOP 111
  - ACTIVATE 011
  - READ 101
  - WRITE 100
  - PRECHARGE 010
  - REFRESH 001
- Command pins are driven from registered state only; there is no combinational path from any u_* input.
- Each command is held exactly one cycle; NOP otherwise.
- Request handshake:
  - u_req_ready=1 only in IDLE with refresh pending=0.
  - Accept when u_req_valid && u_req_ready; latch addr, we and wdata.
  - u_req_ready drops the cycle after acceptance.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RD, WR, REF, REF_WAIT.
- IDLE:
  - Refresh pending with any bank open -> PRE (all-bank).
  - Refresh pending with no bank open -> REF.
  - On accept, row hit (bank open, same row) -> RD/WR.
  - On accept, row conflict -> PRE (single bank; dram_addr = the bank's open row).
  - On accept, bank closed -> ACT.
  - Refresh has priority over a simultaneous request: ready is already 0.
- PRE -> PRE_WAIT for T_RP-1 cycles (skipped if T_RP=1).
  - Then go to REF if refresh target, ACT if request target, IDLE if close-page.
  - All-bank PRE sets dram_pre_all=1 and closes every bank; single PRE closes only bank_id.
- ACT:
  - Drives the row address and marks the bank open with that row.
  - Then ACT_WAIT for T_RCD-1 cycles, then RD/WR.
- RD/WR:
  - Drive the column address; WR drives dram_wr_data.
  - Then go to IDLE, or to PRE (single bank) if CLOSE_PAGE=1.
- REF -> REF_WAIT for T_RFC-1 cycles -> IDLE. REF clears refresh pending.
- Command spacing is exact:
  - ACT@t -> column command @t+T_RCD.
  - PRE@t -> next command @t+T_RP.
  - REF@t -> IDLE @t+T_RFC, with ready=1 @t+T_RFC if nothing is pending.
- Minimum request-to-command latency: request accepted @t -> first DRAM command @t+1.
- Read return:
  - READ@t -> dram_rd_data sampled @t+CAS_LATENCY.
  - u_rdata/u_rdata_valid @t+CAS_LATENCY+1.
  - The shift-register pipeline tolerates back-to-back reads; u_rdata holds its value between strobes.
- Refresh counter:
  - Free-running down-counter; at 0 it sets pending and reloads REFRESH_INTERVAL-1.
  - Expiry while pending already set is absorbed (no queueing).
  - Pending never interrupts an in-flight sequence; it is taken at the next IDLE.
- Reset mid-operation aborts immediately: no partial command, banks closed, read pipeline flushed (no u_rdata_valid).

Test Plan:
- Closed bank read: bank 2, row 5, col 3 -> ACT (row 5) @t+1, READ (col 3) @t+3, u_rdata_valid @t+6 with u_rdata = dram_rd_data sampled @t+5.
- Row hit write: after the row is open, write 0xA5 to the same row, col 1 -> WR @t+1 with dram_wr_data=0xA5, no ACT.
- Row conflict: bank 2 open row 5; read row 9 -> PRE (addr 5, pre_all=0) @t+1, ACT row 9 @t+3, READ @t+5.
- Refresh with REFRESH_INTERVAL=20 and bank 0 open:
  - ready=0 once pending.
  - PRE with pre_all=1, then REF after 2 cycles, then ready=1 4 cycles after REF.
  - All banks read back closed (next access issues ACT).
- CLOSE_PAGE=1: two writes to the same row -> each is followed by PRE, and the second write re-issues ACT.
- Assert u_rst in ACT_WAIT -> all outputs at reset values the same cycle; a pending read produces no u_rdata_valid.

Source files
------------

// File: rtl/dram_timed_controller.sv
// Single-rank DRAM command controller with programmable timing,
// internal refresh, open/close page policy and CAS-latency read return.
module dram_timed_controller #(
   parameter int NUMBER_OF_COLUMNS = 8,
   parameter int NUMBER_OF_ROWS    = 128,
   parameter int NUMBER_OF_BANKS   = 8,
   parameter int DATA_WIDTH        = 8,
   parameter int T_RCD             = 2,
   parameter int T_RP              = 2,
   parameter int T_RFC             = 4,
   parameter int CAS_LATENCY       = 2,
   parameter int REFRESH_INTERVAL  = 1250,
   parameter bit CLOSE_PAGE        = 1'b0,
   localparam int COLUMN_WIDTH     = $clog2(NUMBER_OF_COLUMNS),
   localparam int ROW_WIDTH        = $clog2(NUMBER_OF_ROWS),
   localparam int BANK_ID_WIDTH    = $clog2(NUMBER_OF_BANKS),
   localparam int U_ADDR_WIDTH     = COLUMN_WIDTH + ROW_WIDTH + BANK_ID_WIDTH,
   localparam int DRAM_ADDR_WIDTH  = (ROW_WIDTH > COLUMN_WIDTH) ?
                                     ROW_WIDTH : COLUMN_WIDTH
) (
   input  logic                       u_clk,
   input  logic                       u_rst,
   input  logic                       u_req_valid,
   output logic                       u_req_ready,
   input  logic                       u_req_we,
   input  logic [U_ADDR_WIDTH-1:0]    u_addr,
   input  logic [DATA_WIDTH-1:0]      u_wdata,
   output logic [DATA_WIDTH-1:0]      u_rdata,
   output logic                       u_rdata_valid,
   output logic                       u_busy,
   input  logic [DATA_WIDTH-1:0]      dram_rd_data,
   output logic [DATA_WIDTH-1:0]      dram_wr_data,
   output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
   output logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
   output logic                       dram_pre_all,
   output logic                       dram_cs_n,
   output logic                       dram_ras_n,
   output logic                       dram_cas_n,
   output logic                       dram_we_n,
   output logic                       dram_clk_en
);

   localparam int WMAX = (T_RP > T_RCD) ? ((T_RP > T_RFC) ? T_RP : T_RFC)
                                        : ((T_RCD > T_RFC) ? T_RCD : T_RFC);
   localparam int WW    = $clog2(WMAX + 1);
   localparam int RW    = $clog2(REFRESH_INTERVAL + 1);
   localparam int RP_W  = (T_RP  > 1) ? T_RP  - 2 : 0;
   localparam int RCD_W = (T_RCD > 1) ? T_RCD - 2 : 0;
   localparam int RFC_W = (T_RFC > 1) ? T_RFC - 2 : 0;

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT,
      S_RD, S_WR, S_REF, S_REF_WAIT
   } state_e;

   typedef enum logic [1:0] {TGT_IDLE, TGT_ACT, TGT_REF} tgt_e;

   state_e                     state_q, state_d;
   tgt_e                       tgt_q, tgt_d;
   logic [WW-1:0]              wcnt_q, wcnt_d;
   logic [BANK_ID_WIDTH-1:0]   bank_q, bank_d;
   logic [ROW_WIDTH-1:0]       row_q, row_d;
   logic [COLUMN_WIDTH-1:0]    col_q, col_d;
   logic                       we_q, we_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic [NUMBER_OF_BANKS-1:0] open_q, open_d;
   logic [ROW_WIDTH-1:0]       orow_q [NUMBER_OF_BANKS];
   logic [ROW_WIDTH-1:0]       orow_d [NUMBER_OF_BANKS];
   logic [RW-1:0]              rcnt_q, rcnt_d;
   logic                       pend_q, pend_d;
   logic                       en_q;
   logic [CAS_LATENCY-1:0]     pipe_q, pipe_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic                       rvalid_q, rvalid_d;

   logic [BANK_ID_WIDTH-1:0]   in_bank;
   logic [ROW_WIDTH-1:0]       in_row;
   logic [COLUMN_WIDTH-1:0]    in_col;
   logic                       accept;
   logic                       hit;
   logic                       expire;
   state_e                     pre_next;
   state_e                     col_next;
   logic [2:0]                 cmd;

   assign in_col  = u_addr[COLUMN_WIDTH-1:0];
   assign in_row  = u_addr[COLUMN_WIDTH +: ROW_WIDTH];
   assign in_bank = u_addr[COLUMN_WIDTH+ROW_WIDTH +: BANK_ID_WIDTH];

   assign u_req_ready = en_q && !pend_q && (state_q == S_IDLE);
   assign accept      = u_req_valid && u_req_ready;
   assign hit         = open_q[in_bank] && (orow_q[in_bank] == in_row);
   assign expire      = (rcnt_q == '0);

   assign u_busy        = (state_q != S_IDLE);
   assign u_rdata       = rdata_q;
   assign u_rdata_valid = rvalid_q;
   assign dram_clk_en   = en_q;
   assign dram_cs_n     = !en_q;
   assign dram_ras_n    = cmd[2];
   assign dram_cas_n    = cmd[1];
   assign dram_we_n     = cmd[0];

   always_comb begin
      pre_next = S_IDLE;
      unique case (tgt_q)
         TGT_REF: pre_next = S_REF;
         TGT_ACT: pre_next = S_ACT;
         default: pre_next = S_IDLE;
      endcase
      col_next = we_q ? S_WR : S_RD;
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      wcnt_d  = wcnt_q;
      bank_d  = bank_q;
      row_d   = row_q;
      col_d   = col_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      open_d  = open_q;
      orow_d  = orow_q;
      unique case (state_q)
         S_IDLE: begin
            if (en_q && pend_q) begin
               if (|open_q) begin
                  state_d = S_PRE;
                  tgt_d   = TGT_REF;
               end else begin
                  state_d = S_REF;
               end
            end else if (accept) begin
               bank_d  = in_bank;
               row_d   = in_row;
               col_d   = in_col;
               we_d    = u_req_we;
               wdata_d = u_wdata;
               if (hit) begin
                  state_d = u_req_we ? S_WR : S_RD;
               end else if (open_q[in_bank]) begin
                  state_d = S_PRE;
                  tgt_d   = TGT_ACT;
               end else begin
                  state_d = S_ACT;
               end
            end
         end
         S_PRE: begin
            if (tgt_q == TGT_REF) open_d = '0;
            else open_d[bank_q] = 1'b0;
            if (T_RP > 1) begin
               state_d = S_PRE_WAIT;
               wcnt_d  = WW'(RP_W);
            end else begin
               state_d = pre_next;
            end
         end
         S_PRE_WAIT: begin
            if (wcnt_q == '0) state_d = pre_next;
            else wcnt_d = wcnt_q - WW'(1);
         end
         S_ACT: begin
            open_d[bank_q] = 1'b1;
            orow_d[bank_q] = row_q;
            if (T_RCD > 1) begin
               state_d = S_ACT_WAIT;
               wcnt_d  = WW'(RCD_W);
            end else begin
               state_d = col_next;
            end
         end
         S_ACT_WAIT: begin
            if (wcnt_q == '0) state_d = col_next;
            else wcnt_d = wcnt_q - WW'(1);
         end
         S_RD, S_WR: begin
            if (CLOSE_PAGE) begin
               state_d = S_PRE;
               tgt_d   = TGT_IDLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REF: begin
            if (T_RFC > 1) begin
               state_d = S_REF_WAIT;
               wcnt_d  = WW'(RFC_W);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REF_WAIT: begin
            if (wcnt_q == '0) state_d = S_IDLE;
            else wcnt_d = wcnt_q - WW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A new expiry in the REF cycle itself re-arms pending.
   always_comb begin
      rcnt_d = expire ? RW'(REFRESH_INTERVAL - 1) : rcnt_q - RW'(1);
      pend_d = (pend_q && (state_q != S_REF)) || expire;
   end

   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = (state_q == S_RD);
      for (int i = 1; i < CAS_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      rvalid_d = pipe_q[CAS_LATENCY-1];
      rdata_d  = pipe_q[CAS_LATENCY-1] ? dram_rd_data : rdata_q;
   end

   always_comb begin
      cmd          = 3'b111;
      dram_addr    = '0;
      dram_bank_id = '0;
      dram_pre_all = 1'b0;
      dram_wr_data = '0;
      unique case (state_q)
         S_PRE: begin
            cmd          = 3'b010;
            dram_bank_id = bank_q;
            if (tgt_q == TGT_REF) dram_pre_all = 1'b1;
            else dram_addr = DRAM_ADDR_WIDTH'(orow_q[bank_q]);
         end
         S_ACT: begin
            cmd          = 3'b011;
            dram_bank_id = bank_q;
            dram_addr    = DRAM_ADDR_WIDTH'(row_q);
         end
         S_RD: begin
            cmd          = 3'b101;
            dram_bank_id = bank_q;
            dram_addr    = DRAM_ADDR_WIDTH'(col_q);
         end
         S_WR: begin
            cmd          = 3'b100;
            dram_bank_id = bank_q;
            dram_addr    = DRAM_ADDR_WIDTH'(col_q);
            dram_wr_data = wdata_q;
         end
         S_REF:   cmd = 3'b001;
         default: cmd = 3'b111;
      endcase
   end

   always_ff @(posedge u_clk or posedge u_rst) begin
      if (u_rst) begin
         state_q  <= S_IDLE;
         tgt_q    <= TGT_IDLE;
         wcnt_q   <= '0;
         bank_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         open_q   <= '0;
         orow_q   <= '{default: '0};
         rcnt_q   <= RW'(REFRESH_INTERVAL - 1);
         pend_q   <= 1'b0;
         en_q     <= 1'b0;
         pipe_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         wcnt_q   <= wcnt_d;
         bank_q   <= bank_d;
         row_q    <= row_d;
         col_q    <= col_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         open_q   <= open_d;
         orow_q   <= orow_d;
         rcnt_q   <= rcnt_d;
         pend_q   <= pend_d;
         en_q     <= 1'b1;
         pipe_q   <= pipe_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_dram_timed_controller.sv
// Bench for dram_timed_controller: a cycle-stamped command schedule built
// from the timing rules is compared against both page policies.
module tb_dram_timed_controller;

   localparam int NB   = 8;
   localparam int CL   = 2;
   localparam int TRCD = 2;
   localparam int TRP  = 2;
   localparam int TRFC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid, we, sel;
   logic [12:0] addr;
   logic [7:0]  wdata, drd;

   logic       r1, rv1, bz1, pa1, cs1, ras1, cas1, we1, ce1;
   logic [7:0] rd1, wd1;
   logic [6:0] ad1;
   logic [2:0] ba1;
   logic       r2, rv2, bz2, pa2, cs2, ras2, cas2, we2, ce2;
   logic [7:0] rd2, wd2;
   logic [6:0] ad2;
   logic [2:0] ba2;

   dram_timed_controller #(.REFRESH_INTERVAL(20), .CLOSE_PAGE(1'b0)) u_open (
      .u_clk(clk), .u_rst(rst), .u_req_valid(valid), .u_req_ready(r1),
      .u_req_we(we), .u_addr(addr), .u_wdata(wdata), .u_rdata(rd1),
      .u_rdata_valid(rv1), .u_busy(bz1), .dram_rd_data(drd),
      .dram_wr_data(wd1), .dram_addr(ad1), .dram_bank_id(ba1),
      .dram_pre_all(pa1), .dram_cs_n(cs1), .dram_ras_n(ras1),
      .dram_cas_n(cas1), .dram_we_n(we1), .dram_clk_en(ce1));

   dram_timed_controller #(.REFRESH_INTERVAL(40), .CLOSE_PAGE(1'b1)) u_close (
      .u_clk(clk), .u_rst(rst), .u_req_valid(valid), .u_req_ready(r2),
      .u_req_we(we), .u_addr(addr), .u_wdata(wdata), .u_rdata(rd2),
      .u_rdata_valid(rv2), .u_busy(bz2), .dram_rd_data(drd),
      .dram_wr_data(wd2), .dram_addr(ad2), .dram_bank_id(ba2),
      .dram_pre_all(pa2), .dram_cs_n(cs2), .dram_ras_n(ras2),
      .dram_cas_n(cas2), .dram_we_n(we2), .dram_clk_en(ce2));

   logic       c_ready, c_rv, c_busy, c_pa, c_cs, c_ras, c_cas, c_we, c_ce;
   logic [7:0] c_rd, c_wd;
   logic [6:0] c_ad;
   logic [2:0] c_ba;

   assign c_ready = sel ? r2   : r1;
   assign c_rv    = sel ? rv2  : rv1;
   assign c_busy  = sel ? bz2  : bz1;
   assign c_pa    = sel ? pa2  : pa1;
   assign c_cs    = sel ? cs2  : cs1;
   assign c_ras   = sel ? ras2 : ras1;
   assign c_cas   = sel ? cas2 : cas1;
   assign c_we    = sel ? we2  : we1;
   assign c_ce    = sel ? ce2  : ce1;
   assign c_rd    = sel ? rd2  : rd1;
   assign c_wd    = sel ? wd2  : wd1;
   assign c_ad    = sel ? ad2  : ad1;
   assign c_ba    = sel ? ba2  : ba1;

   typedef struct {
      logic [2:0] pins;
      logic       pa;
      bit         chk_ba;
      logic [2:0] bank;
      logic [6:0] addr;
      bit         chk_wd;
      logic [7:0] wd;
   } cmd_t;

   int total = 0;
   int bad   = 0;

   int         n, idle_at, last_ref, ival, last_rd;
   bit         pend, cp;
   bit         opn  [NB];
   logic [6:0] rowv [NB];
   cmd_t       ecmd [int];
   bit         erv  [int];
   int         drd_h[int];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   function automatic void sched(input int t, input logic [2:0] p,
                                 input logic pa, input bit cb,
                                 input logic [2:0] b, input logic [6:0] a,
                                 input bit cw, input logic [7:0] d);
      cmd_t e;
      e.pins = p; e.pa = pa; e.chk_ba = cb; e.bank = b;
      e.addr = a; e.chk_wd = cw; e.wd = d;
      ecmd[t] = e;
   endfunction

   function automatic logic [12:0] mk(input int b, input int r, input int c);
      return {3'(b), 7'(r), 3'(c)};
   endfunction

   function automatic logic [12:0] rnd_addr();
      int r;
      case ($urandom_range(0, 2))
         0:       r = 5;
         1:       r = 9;
         default: r = 100;
      endcase
      return mk(int'($urandom_range(0, 3)), r, int'($urandom_range(0, 7)));
   endfunction

   task automatic model_reset(input int iv, input bit c);
      n = 0; idle_at = 0; pend = 0; last_ref = -10;
      ival = iv; cp = c; last_rd = 0;
      for (int i = 0; i < NB; i++) begin
         opn[i] = 0;
         rowv[i] = '0;
      end
      ecmd.delete(); erv.delete(); drd_h.delete();
   endtask

   // Called at a falling edge: check cycle n, drive inputs, advance model.
   task automatic step(input bit v, input bit w, input logic [12:0] a,
                       input logic [7:0] d, output bit acc);
      cmd_t       e;
      bit         en, idle, rdy, any;
      logic [2:0] b, c;
      logic [6:0] r;
      int         t, cc;
      acc = 0;
      if (n > 0 && n % ival == 0) pend = 1;
      else if (n == last_ref + 1) pend = 0;
      en   = (n >= 1);
      idle = (n >= idle_at);
      rdy  = en && idle && !pend;
      chk("ready", 32'(c_ready), 32'(rdy));
      chk("busy", 32'(c_busy), 32'(!idle));
      chk("clk_en", 32'(c_ce), 32'(en));
      if (ecmd.exists(n)) e = ecmd[n];
      else begin
         e.pins = 3'b111; e.pa = 0; e.chk_ba = 0; e.chk_wd = 0;
         e.bank = '0; e.addr = '0; e.wd = '0;
      end
      chk("cmd", 32'({c_cs, c_ras, c_cas, c_we, c_pa}),
          32'({!en, e.pins, e.pa}));
      if (e.chk_ba) chk("bank_addr", 32'({c_ba, c_ad}), 32'({e.bank, e.addr}));
      if (e.chk_wd) chk("wr_data", 32'(c_wd), 32'(e.wd));
      if (erv.exists(n)) last_rd = drd_h[n-1];
      chk("rvalid", 32'(c_rv), 32'(erv.exists(n)));
      chk("rdata", 32'(c_rd), 32'(last_rd));
      valid = v; we = w; addr = a; wdata = d;
      drd = 8'($urandom);
      drd_h[n] = int'(drd);
      if (idle && en && pend) begin
         any = 0;
         for (int i = 0; i < NB; i++) any |= opn[i];
         t = n + 1;
         if (any) begin
            sched(t, 3'b010, 1'b1, 0, '0, '0, 0, '0);
            t += TRP;
            for (int i = 0; i < NB; i++) opn[i] = 0;
         end
         sched(t, 3'b001, 1'b0, 0, '0, '0, 0, '0);
         last_ref = t;
         idle_at  = t + TRFC;
      end else if (rdy && v) begin
         acc = 1;
         b = a[12:10]; r = a[9:3]; c = a[2:0];
         t = n + 1;
         if (opn[b] && rowv[b] == r) cc = t;
         else begin
            if (opn[b]) begin
               sched(t, 3'b010, 1'b0, 1, b, rowv[b], 0, '0);
               t += TRP;
            end
            sched(t, 3'b011, 1'b0, 1, b, r, 0, '0);
            cc = t + TRCD;
         end
         opn[b] = 1; rowv[b] = r;
         sched(cc, w ? 3'b100 : 3'b101, 1'b0, 1, b, 7'(c), w, d);
         if (!w) erv[cc + CL + 1] = 1;
         if (cp) begin
            sched(cc + 1, 3'b010, 1'b0, 1, b, r, 0, '0);
            opn[b] = 0;
            idle_at = cc + 1 + TRP;
         end else begin
            idle_at = cc + 1;
         end
      end
      @(posedge clk);
      n++;
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      bit acc;
      repeat (k) step(0, 0, '0, '0, acc);
   endtask

   task automatic req(input bit w, input logic [12:0] a, input logic [7:0] d);
      bit acc;
      acc = 0;
      for (int k = 0; k < 60 && !acc; k++) step(1, w, a, d, acc);
      if (!acc) begin
         total++;
         bad++;
         $error("FAIL req_timeout: got no accept expected accept (addr %0h)", a);
      end
   endtask

   task automatic rand_run(input int k);
      bit acc;
      repeat (k) step($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                      rnd_addr(), 8'($urandom), acc);
   endtask

   task automatic rst_chk();
      chk("rst_ready", 32'(c_ready), 32'(0));
      chk("rst_rdata", 32'(c_rd), 32'(0));
      chk("rst_rvalid", 32'(c_rv), 32'(0));
      chk("rst_busy", 32'(c_busy), 32'(0));
      chk("rst_clk_en", 32'(c_ce), 32'(0));
      chk("rst_pins", 32'({c_cs, c_ras, c_cas, c_we, c_pa}), 32'(5'b11110));
      chk("rst_addr", 32'(c_ad), 32'(0));
      chk("rst_bank", 32'(c_ba), 32'(0));
      chk("rst_wdata", 32'(c_wd), 32'(0));
   endtask

   initial begin
      sel = 0; rst = 1; valid = 0; we = 0; addr = '0; wdata = '0; drd = '0;
      n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_chk();
      rst = 0;
      model_reset(20, 0);
      idle(2);
      req(0, mk(2, 5, 3), 8'h00);
      idle(8);
      req(1, mk(2, 5, 1), 8'hA5);
      idle(4);
      req(0, mk(2, 9, 4), 8'h00);
      idle(10);
      rand_run(500);
      idle(20);

      rst = 1;
      @(negedge clk);
      rst = 0;
      model_reset(20, 0);
      req(0, mk(1, 3, 2), 8'h00);
      idle(1);
      rst = 1;
      #1;
      rst_chk();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset(20, 0);
      idle(15);

      rst = 1;
      sel = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset(40, 1);
      idle(2);
      req(1, mk(1, 4, 2), 8'h3C);
      req(1, mk(1, 4, 3), 8'hC3);
      idle(8);
      rand_run(400);
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
